// File: rtl/rf_wb_regfile_if.sv
// Bundle of write-back and read-port signals between the pipeline and the register file.
interface rf_wb_regfile_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [DATA_W-1:0] rf_w_data_DM_WB;
    logic [ADDR_W-1:0] rf_dst_addr_DM_WB;
    logic              rf_we_DM_WB;
    logic              stall_ID_EX;
    logic [ADDR_W-1:0] p0_addr;
    logic [ADDR_W-1:0] p1_addr;
    logic              re0;
    logic              re1;
    logic [DATA_W-1:0] p0;
    logic [DATA_W-1:0] p1;

    // Pipeline side: drives the write-back and read requests, receives read data.
    modport master (
        output rf_w_data_DM_WB, rf_dst_addr_DM_WB, rf_we_DM_WB, stall_ID_EX,
        output p0_addr, p1_addr, re0, re1,
        input  p0, p1
    );

    // Register file side.
    modport slave (
        input  rf_w_data_DM_WB, rf_dst_addr_DM_WB, rf_we_DM_WB, stall_ID_EX,
        input  p0_addr, p1_addr, re0, re1,
        output p0, p1
    );
endinterface

// File: rtl/rf_wb_regfile.sv
// Architectural register file terminating the write-back path.
// One write port from DM_WB, two registered read ports towards ID/EX with
// same-cycle write-through bypass. R0 is hardwired to zero.
module rf_wb_regfile #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    rf_wb_regfile_if.slave  bus
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_p0;
    logic [DATA_W-1:0] r_p1;
    logic [DATA_W-1:0] w_rd0;
    logic [DATA_W-1:0] w_rd1;
    logic              w_wr_valid;

    // A write to R0 is dropped so R0 keeps reading zero.
    assign w_wr_valid = bus.rf_we_DM_WB && (bus.rf_dst_addr_DM_WB != '0);

    // Commit write-back data; writes are never held off by a pipeline stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[bus.rf_dst_addr_DM_WB] <= bus.rf_w_data_DM_WB;
        end
    end

    // Read value per port: zero for R0, bypassed write data on an address hit, else stored value.
    always_comb begin
        w_rd0 = '0;
        w_rd1 = '0;
        if (bus.p0_addr != '0) begin
            if (bus.rf_we_DM_WB && (bus.rf_dst_addr_DM_WB == bus.p0_addr)) begin
                w_rd0 = bus.rf_w_data_DM_WB;
            end else begin
                w_rd0 = r_regs[bus.p0_addr];
            end
        end
        if (bus.p1_addr != '0) begin
            if (bus.rf_we_DM_WB && (bus.rf_dst_addr_DM_WB == bus.p1_addr)) begin
                w_rd1 = bus.rf_w_data_DM_WB;
            end else begin
                w_rd1 = r_regs[bus.p1_addr];
            end
        end
    end

    // Output registers update only when the ID/EX stage is not stalled and the port is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p0 <= '0;
            r_p1 <= '0;
        end else if (!bus.stall_ID_EX) begin
            if (bus.re0) begin
                r_p0 <= w_rd0;
            end
            if (bus.re1) begin
                r_p1 <= w_rd1;
            end
        end
    end

    assign bus.p0 = r_p0;
    assign bus.p1 = r_p1;

endmodule

// File: tb/tb_rf_wb_regfile.sv
// Self-checking bench for rf_wb_regfile: reference model plus expectation queue,
// followed by directed checks of the notable cases and a random phase.
module tb_rf_wb_regfile;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NUM_REGS = 16;

    typedef struct {
        string             tag;
        logic [DATA_W-1:0] p0;
        logic [DATA_W-1:0] p1;
    } expect_t;

    logic clk;
    logic rst_n;

    rf_wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checkCount = 0;
    int errorCount = 0;

    expect_t           sbQ[$];
    logic [DATA_W-1:0] mRegs [NUM_REGS];
    logic [DATA_W-1:0] mP0;
    logic [DATA_W-1:0] mP1;

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                               input logic [DATA_W-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", tag, observed, expected);
        end
    endtask

    function automatic logic [DATA_W-1:0] modelRead(input logic [ADDR_W-1:0] a,
                                                    input logic we, input logic [ADDR_W-1:0] dst,
                                                    input logic [DATA_W-1:0] data);
        if (a == '0) return '0;
        if (we && dst == a) return data;
        return mRegs[a];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NUM_REGS; i++) mRegs[i] = '0;
        mP0 = '0;
        mP1 = '0;
    endtask

    // Drives one cycle of stimulus at the falling edge, queues the model's outputs,
    // then checks the DUT one time unit after the rising edge.
    task automatic applyStimulus(input string tag, input logic we, input logic [ADDR_W-1:0] dst,
                                 input logic [DATA_W-1:0] data, input logic stall,
                                 input logic [ADDR_W-1:0] a0, input logic r0,
                                 input logic [ADDR_W-1:0] a1, input logic r1);
        expect_t e;
        expect_t got;
        @(negedge clk);
        bus.rf_we_DM_WB       = we;
        bus.rf_dst_addr_DM_WB = dst;
        bus.rf_w_data_DM_WB   = data;
        bus.stall_ID_EX       = stall;
        bus.p0_addr           = a0;
        bus.re0               = r0;
        bus.p1_addr           = a1;
        bus.re1               = r1;
        if (!stall && r0) mP0 = modelRead(a0, we, dst, data);
        if (!stall && r1) mP1 = modelRead(a1, we, dst, data);
        if (we && dst != '0) mRegs[dst] = data;
        e.tag = tag;
        e.p0  = mP0;
        e.p1  = mP1;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        got = sbQ.pop_front();
        checkOutput({got.tag, "_p0"}, bus.p0, got.p0);
        checkOutput({got.tag, "_p1"}, bus.p1, got.p1);
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.rf_we_DM_WB       = 1'b0;
        bus.rf_dst_addr_DM_WB = '0;
        bus.rf_w_data_DM_WB   = '0;
        bus.stall_ID_EX       = 1'b0;
        bus.p0_addr           = '0;
        bus.p1_addr           = '0;
        bus.re0               = 1'b0;
        bus.re1               = 1'b0;
        modelReset();

        // Power-on reset.
        #2;
        checkOutput("por_p0", bus.p0, 16'h0000);
        checkOutput("por_p1", bus.p1, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Load R3 and bring it onto both ports, then reset mid-run.
        applyStimulus("wrR3", 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        applyStimulus("rdR3", 1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 1'b1, 4'd3, 1'b1);
        checkOutput("preRst_p0", bus.p0, 16'hBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("inRst_p0", bus.p0, 16'h0000);
        checkOutput("inRst_p1", bus.p1, 16'h0000);
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("inRstEdge_p0", bus.p0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("postRstR3", 1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0);
        checkOutput("postRstR3_p0", bus.p0, 16'h0000);

        // Basic write then read.
        applyStimulus("wrR5", 1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        applyStimulus("rdR5", 1'b0, 4'd0, 16'h0000, 1'b0, 4'd5, 1'b1, 4'd6, 1'b1);
        checkOutput("basic_p0", bus.p0, 16'h1234);
        checkOutput("basic_p1", bus.p1, 16'h0000);

        // Same-cycle bypass onto both ports.
        applyStimulus("byp7", 1'b1, 4'd7, 16'hA5A5, 1'b0, 4'd7, 1'b1, 4'd7, 1'b1);
        checkOutput("byp_p0", bus.p0, 16'hA5A5);
        checkOutput("byp_p1", bus.p1, 16'hA5A5);

        // R0 stays zero, both committed and bypassed.
        applyStimulus("wrR0", 1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 1'b1, 4'd7, 1'b1);
        checkOutput("r0byp_p0", bus.p0, 16'h0000);
        applyStimulus("rdR0", 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1);
        checkOutput("r0rd_p0", bus.p0, 16'h0000);

        // Stall holds outputs while write commits; read after stall sees stored value.
        applyStimulus("wrR2", 1'b1, 4'd2, 16'h1111, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        applyStimulus("rdR2", 1'b0, 4'd0, 16'h0000, 1'b0, 4'd2, 1'b1, 4'd5, 1'b1);
        checkOutput("rdR2_p0", bus.p0, 16'h1111);
        applyStimulus("stallWr", 1'b1, 4'd2, 16'h2222, 1'b1, 4'd2, 1'b1, 4'd7, 1'b1);
        checkOutput("stall_p0", bus.p0, 16'h1111);
        checkOutput("stall_p1", bus.p1, 16'h1234);
        applyStimulus("unstall", 1'b0, 4'd0, 16'h0000, 1'b0, 4'd2, 1'b1, 4'd7, 1'b0);
        checkOutput("unstall_p0", bus.p0, 16'h2222);
        checkOutput("re1Hold_p1", bus.p1, 16'h1234);
        applyStimulus("re1Hold2", 1'b0, 4'd0, 16'h0000, 1'b0, 4'd5, 1'b0, 4'd3, 1'b0);
        checkOutput("re0Hold_p0", bus.p0, 16'h2222);

        // JAL link register alongside an unrelated read.
        applyStimulus("wrR14", 1'b1, 4'd14, 16'h0E0E, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        applyStimulus("wrR15", 1'b1, 4'd15, 16'h0042, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        applyStimulus("rdJal", 1'b0, 4'd0, 16'h0000, 1'b0, 4'd14, 1'b1, 4'd15, 1'b1);
        checkOutput("jal_p1", bus.p1, 16'h0042);
        checkOutput("jal_p0", bus.p0, 16'h0E0E);

        // Random traffic against the model.
        for (int i = 0; i < 200; i++) begin
            applyStimulus($sformatf("rnd%0d", i),
                          1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom),
                          ($urandom_range(0, 4) == 0), 4'($urandom), 1'($urandom_range(0, 1)),
                          4'($urandom), 1'($urandom_range(0, 1)));
        end
        idle("tail");

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/rf_wb_regfile.md
Name: rf_wb_regfile

Overview:
- Register file that terminates the write-back path. It consumes the registered write data produced at the end of the DM_WB stage and commits it to architectural registers.
- Provides two registered read ports to the ID/EX boundary.
- Includes same-cycle write-through bypass, so an instruction reading a register written in the same cycle gets the new value.
- R0 is hardwired to zero. R15 is the JAL link register; it needs no special handling because the link value arrives as ordinary write data.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, register address width.
- NUM_REGS, 16, register count (2**ADDR_W).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- rf_w_data_DM_WB  input  DATA_W  write data from the write-back mux (ALU result, DM read data, or JAL PC).
- rf_dst_addr_DM_WB  input  ADDR_W  destination register of the write-back instruction.
- rf_we_DM_WB  input  1  write enable of the write-back instruction.
- stall_ID_EX  input  1  hold read-port outputs.
- p0_addr  input  ADDR_W  read port 0 address.
- p1_addr  input  ADDR_W  read port 1 address.
- re0  input  1  read enable, port 0.
- re1  input  1  read enable, port 1.
- p0  output  DATA_W  registered read data, port 0.
- p1  output  DATA_W  registered read data, port 1.

Behaviour:
- Reset:
  - rst_n low asynchronously clears all NUM_REGS registers to 0, p0 to 0 and p1 to 0.
  - State stays cleared while rst_n is low.
  - The first write is accepted on the first posedge after rst_n is released.
- Write:
  - On posedge with rf_we_DM_WB=1 and rf_dst_addr_DM_WB != 0, reg[rf_dst_addr_DM_WB] <= rf_w_data_DM_WB.
  - Writes are not gated by stall_ID_EX; write-back always commits.
  - Writes to address 0 are discarded. R0 always reads 0.
- Read, per port n:
  - On posedge, if stall_ID_EX=0 and re_n=1, pn <= value(pn_addr).
  - value(a) = 0 if a==0.
  - Otherwise value(a) = rf_w_data_DM_WB if rf_we_DM_WB=1 and rf_dst_addr_DM_WB==a (write-through bypass).
  - Otherwise value(a) = reg[a].
- Hold conditions:
  - If stall_ID_EX=1, pn holds its value regardless of re_n.
  - If re_n=0, pn holds its value.
- Latency:
  - Read: 1 cycle from address to pn.
  - Write-to-read visibility: 0 cycles. A write and a read to the same address in the same cycle return the new data at the next edge.
- Simultaneous events:
  - Both ports may read the same address.
  - Both ports may bypass from the single write port in the same cycle.
  - Write and stall in the same cycle: the write commits and pn holds. A read issued after the stall releases sees the written value from reg[], not from bypass.
- Width: no arithmetic. Data passes unmodified; no sign or zero extension.
- Reset mid-operation: rst_n falling at any time immediately clears all state. An in-flight write on that edge is lost.
- Undefined addresses: none. All 2**ADDR_W addresses are valid.

Test Plan:
- Reset clear: rst_n=0 mid-run after writing R3=0xBEEF, then release; read R3 on p0 -> p0=0x0000 one cycle later; p0 and p1 read 0 while rst_n is low.
- Basic write/read: write R5=0x1234, next cycle re0=1, p0_addr=5 -> p0=0x1234 after one edge; p1 reading R6 returns 0.
- Bypass: in the same cycle write R7=0xA5A5 and read p0_addr=7, p1_addr=7 with re0=re1=1 -> p0=p1=0xA5A5 at the next edge.
- R0 protection: write R0=0xFFFF with rf_we_DM_WB=1, then read p0_addr=0 -> p0=0x0000, including in the same-cycle bypass case.
- Stall/enable hold:
  - p0=0x1111 from R2. Assert stall_ID_EX while writing R2=0x2222 -> p0 stays 0x1111.
  - Deassert stall with re0=1 -> p0=0x2222.
  - With re1=0, p1 holds its prior value across address changes.
- JAL link: write R15=0x0042 with data from the write-back path, read R15 on p1 -> p1=0x0042; reading R14 on p0 in the same cycle is unaffected.
